// File: rtl/fetch_pc.sv
// Program counter and fetch sequencer: IDLE/RUN/HALTED control, absolute branch
// targets from a loadable LUT, and a saturating retired-instruction counter.
module fetch_pc #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              jump_flag,
  input  logic [LUT_AW-1:0] jump_idx,
  input  logic              halt_req,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  output logic [PC_W-1:0]   pc,
  output logic              running,
  output logic              done,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_HALTED = 2'b10;
  localparam int         LUT_N     = 1 << LUT_AW;

  logic [1:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [PC_W-1:0]  lut_q [LUT_N];
  logic [PC_W-1:0]  lut_d [LUT_N];
  logic [PC_W-1:0]  jump_tgt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [PC_W-1:0] wrap_inc(input logic [PC_W-1:0] v);
    return v + PC_W'(1);
  endfunction

  // Read comes from the registered table, so a same-cycle write is not seen.
  assign jump_tgt = lut_q[jump_idx];

  always_comb begin
    lut_d = lut_q;
    if (lut_we) begin
      lut_d[lut_waddr] = lut_wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    case (state_q)
      ST_IDLE: begin
        pc_d = '0;
        if (start) begin
          state_d   = ST_RUN;
          retired_d = '0;
        end
      end
      ST_RUN: begin
        retired_d = sat_inc(retired_q);
        if (halt_req) begin
          state_d = ST_HALTED;
        end else if (jump_flag) begin
          pc_d = jump_tgt;
        end else begin
          pc_d = wrap_inc(pc_q);
        end
      end
      ST_HALTED: begin
        if (start) begin
          state_d   = ST_RUN;
          pc_d      = '0;
          retired_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      retired_q <= '0;
      for (int i = 0; i < LUT_N; i++) begin
        lut_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      lut_q     <= lut_d;
    end
  end

  assign pc      = pc_q;
  assign running = (state_q == ST_RUN);
  assign done    = (state_q == ST_HALTED);
  assign retired = retired_q;

endmodule

// File: tb/tb_fetch_pc.sv
// Bench for fetch_pc: directed scenarios followed by a randomized run, all
// compared against a cycle-level behavioural model of the sequencer.
module tb_fetch_pc;

  localparam int PC_W   = 10;
  localparam int LUT_AW = 4;
  localparam int CNT_W  = 16;
  localparam int LUT_N  = 1 << LUT_AW;
  localparam int PC_MOD = 1 << PC_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              jump_flag;
  logic [LUT_AW-1:0] jump_idx;
  logic              halt_req;
  logic              lut_we;
  logic [LUT_AW-1:0] lut_waddr;
  logic [PC_W-1:0]   lut_wdata;
  logic [PC_W-1:0]   pc;
  logic              running;
  logic              done;
  logic [CNT_W-1:0]  retired;

  int total = 0;
  int bad   = 0;

  typedef enum {M_IDLE, M_RUN, M_HALTED} mstate_t;
  mstate_t mst;
  int      mpc;
  int      mret;
  int      mlut [LUT_N];

  fetch_pc #(.PC_W(PC_W), .LUT_AW(LUT_AW), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .jump_flag (jump_flag),
    .jump_idx  (jump_idx),
    .halt_req  (halt_req),
    .lut_we    (lut_we),
    .lut_waddr (lut_waddr),
    .lut_wdata (lut_wdata),
    .pc        (pc),
    .running   (running),
    .done      (done),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_pc"}, 32'(pc), 32'(mpc));
    chk({tag, "_running"}, 32'(running), 32'(mst == M_RUN));
    chk({tag, "_done"}, 32'(done), 32'(mst == M_HALTED));
    chk({tag, "_retired"}, 32'(retired), 32'(mret));
  endtask

  task automatic model_reset();
    mst  = M_IDLE;
    mpc  = 0;
    mret = 0;
    for (int i = 0; i < LUT_N; i++) mlut[i] = 0;
  endtask

  // One clock edge of the sequencer, from the rules: halt beats jump beats increment.
  task automatic model_edge();
    int tgt;
    tgt = mlut[jump_idx];
    case (mst)
      M_IDLE: begin
        if (start) begin mst = M_RUN; mpc = 0; mret = 0; end
      end
      M_RUN: begin
        mret = (mret >= CNT_MAX) ? CNT_MAX : mret + 1;
        if (halt_req)       mst = M_HALTED;
        else if (jump_flag) mpc = tgt;
        else                mpc = (mpc + 1) % PC_MOD;
      end
      M_HALTED: begin
        if (start) begin mst = M_RUN; mpc = 0; mret = 0; end
      end
    endcase
    if (lut_we) mlut[lut_waddr] = int'(lut_wdata);
  endtask

  task automatic step(input logic s, input logic jf, input int idx, input logic h,
                      input logic we, input int wa, input int wd, input string tag);
    start     = s;
    jump_flag = jf;
    jump_idx  = LUT_AW'(idx);
    halt_req  = h;
    lut_we    = we;
    lut_waddr = LUT_AW'(wa);
    lut_wdata = PC_W'(wd);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, "seq");
  endtask

  task automatic wr(input int a, input int d);
    step(0, 0, 0, 0, 1, a, d, "wr");
  endtask

  task automatic async_reset(input string tag);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int r0;
    reset = 1'b1;
    start = 0; jump_flag = 0; jump_idx = '0; halt_req = 0;
    lut_we = 0; lut_waddr = '0; lut_wdata = '0;
    model_reset();
    #12;
    check_all("reset");
    reset = 1'b0;

    // Plain sequential run
    step(1, 0, 0, 0, 0, 0, 0, "start");
    chk("start_pc", 32'(pc), 32'd0);
    seq(5);
    chk("seq5_pc", 32'(pc), 32'd5);
    chk("seq5_ret", 32'(retired), 32'd5);
    chk("seq5_done", 32'(done), 32'd0);
    chk("seq5_run", 32'(running), 32'd1);

    // Taken jump, then sequential after target
    wr(3, 'h040);
    seq(1);
    chk("pre_jump_pc", 32'(pc), 32'd7);
    step(0, 1, 3, 0, 0, 0, 0, "jump3");
    chk("jump3_pc", 32'(pc), 32'h040);
    seq(1);
    chk("after_jump_pc", 32'(pc), 32'h041);

    // Same-cycle LUT write and read sees old contents
    wr(2, 'h020);
    step(0, 1, 2, 0, 1, 2, 'h100, "wr_rd_same");
    chk("wr_rd_old", 32'(pc), 32'h020);
    step(0, 1, 2, 0, 0, 0, 0, "jump2_new");
    chk("wr_rd_new", 32'(pc), 32'h100);

    // Halt has priority over jump
    wr(4, 'h011);
    step(0, 1, 4, 0, 0, 0, 0, "jump4");
    seq(1);
    chk("pre_halt_pc", 32'(pc), 32'h012);
    r0 = mret;
    step(0, 1, 3, 1, 0, 0, 0, "halt");
    chk("halt_pc", 32'(pc), 32'h012);
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_run", 32'(running), 32'd0);
    chk("halt_ret", 32'(retired), 32'(r0 + 1));
    step(0, 1, 3, 1, 0, 0, 0, "halted_hold");
    step(1, 0, 0, 0, 0, 0, 0, "restart");
    chk("restart_pc", 32'(pc), 32'd0);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_ret", 32'(retired), 32'd0);

    // pc wraps from all-ones to zero
    wr(5, 'h3FF);
    step(0, 1, 5, 0, 0, 0, 0, "jump_top");
    chk("top_pc", 32'(pc), 32'h3FF);
    seq(1);
    chk("wrap_pc", 32'(pc), 32'd0);
    chk("wrap_run", 32'(running), 32'd1);

    // Asynchronous reset mid-run
    step(0, 0, 0, 1, 0, 0, 0, "halt2");
    step(1, 0, 0, 0, 0, 0, 0, "start3");
    seq(18);
    wr(6, 'h055);
    step(0, 1, 6, 0, 0, 0, 0, "jump6");
    chk("pre_rst_pc", 32'(pc), 32'h055);
    chk("pre_rst_ret", 32'(retired), 32'd20);
    async_reset("async_rst");
    chk("async_rst_pc", 32'(pc), 32'd0);
    chk("async_rst_ret", 32'(retired), 32'd0);
    chk("async_rst_run", 32'(running), 32'd0);
    step(0, 1, 6, 0, 0, 0, 0, "idle_ignore");
    chk("idle_pc", 32'(pc), 32'd0);
    step(1, 0, 0, 0, 0, 0, 0, "start4");
    for (int i = 0; i < LUT_N; i++) begin
      step(0, 1, i, 0, 0, 0, 0, "lut_cleared");
      chk("lut_cleared_pc", 32'(pc), 32'd0);
    end

    // Randomized run against the model
    for (int n = 0; n < 1500; n++) begin
      int wd;
      wd = ($urandom % 8 == 0) ? PC_MOD - 1 - int'($urandom % 3) : int'($urandom % PC_MOD);
      step(($urandom % 20) == 0, ($urandom % 3) == 0, int'($urandom % LUT_N),
           ($urandom % 25) == 0, ($urandom % 4) == 0, int'($urandom % LUT_N), wd, "rand");
      if ($urandom % 300 == 0) async_reset("rand_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
